// File: rtl/logc_pkg.sv
// Shared constants for the log-domain pixel mapping path.
package logc_pkg;

  // Display pixel format
  localparam int PIX_W   = 8;
  localparam int PIX_MAX = 255;

  // Width of the saturating clip counter
  localparam int CLIP_W  = 16;

  // Width of an unsigned log2 value comp_int.comp_frac
  function automatic int calc_lw(input int shift_width, input int frac_width);
    return shift_width + frac_width + 1;
  endfunction

endpackage

// File: rtl/logc_pix_stage.sv
// One pipeline register slice: valid bit, payload and line tag, loaded on en.
module logc_pix_stage
  import logc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_sol,
  input  logic         in_eol,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_sol,
  output logic         out_eol
);

  // Capture the upstream slot whenever the whole pipe advances; bubbles load as valid=0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
      out_sol   <= in_sol;
      out_eol   <= in_eol;
    end
  end

endmodule

// File: rtl/logc_pixel_map.sv
// Maps log2 samples to 8-bit display pixels: black-level subtract, gain, clamp.
// Three lock-step pipeline stages; black/gain are shadowed and switched only at line start.
module logc_pixel_map
  import logc_pkg::*;
#(
  parameter int SHIFT_WIDTH = 6,
  parameter int FRAC_WIDTH  = 16,
  parameter int NORM_WIDTH  = 17,
  parameter int GAIN_WIDTH  = 16,
  parameter int GAIN_FRAC   = 8,
  parameter int LINE_LEN    = 256,
  parameter int DEF_BLACK   = 0,
  parameter int DEF_GAIN    = 256
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SHIFT_WIDTH-1:0]                 comp_int,
  input  logic [NORM_WIDTH-1:0]                  comp_frac,
  input  logic [calc_lw(SHIFT_WIDTH,FRAC_WIDTH)-1:0] cfg_black,
  input  logic [GAIN_WIDTH-1:0]                  cfg_gain,
  input  logic                                   cfg_load,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PIX_W-1:0]                       pix,
  output logic                                   pix_sol,
  output logic                                   pix_eol,
  output logic [CLIP_W-1:0]                      clip_cnt
);

  localparam int LW    = calc_lw(SHIFT_WIDTH, FRAC_WIDTH);
  localparam int DW    = LW + 1;                  // signed difference
  localparam int PW    = DW + GAIN_WIDTH + 1;     // signed product
  localparam int SH    = FRAC_WIDTH + GAIN_FRAC;  // product scale back to integer pixels
  localparam int IDX_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int S1_W  = DW + GAIN_WIDTH;
  localparam int S3_W  = PIX_W + 1;

  logic                  advance;
  logic                  accept;
  logic [IDX_W-1:0]      in_idx;
  logic                  line_start;
  logic                  line_end;

  logic [LW-1:0]         act_black;
  logic [GAIN_WIDTH-1:0] act_gain;
  logic [LW-1:0]         pend_black;
  logic [GAIN_WIDTH-1:0] pend_gain;
  logic                  pend;
  logic                  swap;
  logic [LW-1:0]         eff_black;
  logic [GAIN_WIDTH-1:0] eff_gain;

  logic [LW-1:0]         l_val;
  logic signed [DW-1:0]  d_val;
  logic [S1_W-1:0]       s1_in;

  logic                  s1_valid, s1_sol, s1_eol;
  logic [S1_W-1:0]       s1_data;
  logic signed [DW-1:0]  s1_d;
  logic [GAIN_WIDTH-1:0] s1_gain;
  logic signed [PW-1:0]  p_val;

  logic                  s2_valid, s2_sol, s2_eol;
  logic [PW-1:0]         s2_data;
  logic signed [PW-1:0]  q_val;
  logic                  q_neg;
  logic                  q_over;
  logic [PIX_W-1:0]      pix_val;

  logic [S3_W-1:0]       s3_data;
  logic                  s3_clip;

  assign advance    = !out_valid || out_ready;
  assign in_ready   = advance;
  assign accept     = in_valid && advance;
  assign line_start = (in_idx == '0);
  assign line_end   = (in_idx == IDX_W'(LINE_LEN - 1));

  // A pending config takes over at an accepted line start, unless a new load arrives that same cycle
  assign swap      = accept && line_start && pend && !cfg_load;
  assign eff_black = swap ? pend_black : act_black;
  assign eff_gain  = swap ? pend_gain  : act_gain;

  // S1 arithmetic: assemble the log value and remove the black level
  assign l_val = LW'({comp_int, {FRAC_WIDTH{1'b0}}}) + LW'(comp_frac);
  assign d_val = $signed({1'b0, l_val}) - $signed({1'b0, eff_black});
  assign s1_in = {d_val, eff_gain};

  // S2 arithmetic: signed difference times unsigned gain
  assign s1_d    = $signed(s1_data[S1_W-1:GAIN_WIDTH]);
  assign s1_gain = s1_data[GAIN_WIDTH-1:0];
  assign p_val   = PW'(s1_d) * PW'($signed({1'b0, s1_gain}));

  // S3 arithmetic: floor-scale and clamp to the pixel range
  assign q_val   = $signed(s2_data) >>> SH;
  assign q_neg   = q_val[PW-1];
  assign q_over  = !q_neg && (|q_val[PW-1:PIX_W]);
  assign pix_val = q_neg ? '0 : (q_over ? PIX_W'(PIX_MAX) : q_val[PIX_W-1:0]);

  assign pix     = s3_data[PIX_W-1:0];
  assign s3_clip = s3_data[PIX_W];

  // Sample position within the line; wraps after the last sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_idx <= '0;
    end else if (accept) begin
      in_idx <= line_end ? '0 : in_idx + 1'b1;
    end
  end

  // Config shadow: loads go to pending, pending becomes active at a line start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_black  <= LW'(DEF_BLACK);
      act_gain   <= GAIN_WIDTH'(DEF_GAIN);
      pend_black <= '0;
      pend_gain  <= '0;
      pend       <= 1'b0;
    end else if (cfg_load) begin
      pend_black <= cfg_black;
      pend_gain  <= cfg_gain;
      pend       <= 1'b1;
    end else if (swap) begin
      act_black  <= pend_black;
      act_gain   <= pend_gain;
      pend       <= 1'b0;
    end
  end

  // Clipped-pixel counter: cleared by a config load, saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_cnt <= '0;
    end else if (cfg_load) begin
      clip_cnt <= '0;
    end else if (out_valid && out_ready && s3_clip && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + 1'b1;
    end
  end

  logc_pix_stage #(.W(S1_W)) u_s1 (
    .clk(clk), .reset(reset), .en(advance),
    .in_valid(accept), .in_data(s1_in), .in_sol(line_start), .in_eol(line_end),
    .out_valid(s1_valid), .out_data(s1_data), .out_sol(s1_sol), .out_eol(s1_eol)
  );

  logc_pix_stage #(.W(PW)) u_s2 (
    .clk(clk), .reset(reset), .en(advance),
    .in_valid(s1_valid), .in_data(p_val), .in_sol(s1_sol), .in_eol(s1_eol),
    .out_valid(s2_valid), .out_data(s2_data), .out_sol(s2_sol), .out_eol(s2_eol)
  );

  logc_pix_stage #(.W(S3_W)) u_s3 (
    .clk(clk), .reset(reset), .en(advance),
    .in_valid(s2_valid), .in_data({q_over, pix_val}), .in_sol(s2_sol), .in_eol(s2_eol),
    .out_valid(out_valid), .out_data(s3_data), .out_sol(pix_sol), .out_eol(pix_eol)
  );

endmodule

// File: tb/tb_logc_pixel_map.sv
// Self-checking bench for logc_pixel_map with a 4-sample line.
module tb_logc_pixel_map;

  localparam int LL = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  comp_int;
  logic [16:0] comp_frac;
  logic [22:0] cfg_black;
  logic [15:0] cfg_gain;
  logic        cfg_load;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  pix;
  logic        pix_sol;
  logic        pix_eol;
  logic [15:0] clip_cnt;

  logc_pixel_map #(.LINE_LEN(LL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .comp_int(comp_int), .comp_frac(comp_frac), .cfg_black(cfg_black),
    .cfg_gain(cfg_gain), .cfg_load(cfg_load), .out_valid(out_valid),
    .out_ready(out_ready), .pix(pix), .pix_sol(pix_sol), .pix_eol(pix_eol),
    .clip_cnt(clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pix;
    bit sol;
    bit eol;
    bit clip;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  exp_t obs[$];

  // reference model state
  longint m_black = 0, m_gain = 256, m_pblack = 0, m_pgain = 0;
  bit     m_pend = 0;
  int     m_idx = 0;
  int     m_clip = 0;
  int     n_out = 0;
  bit     prev_stall = 0;
  int     prev_pix = 0;
  bit     prev_sol = 0, prev_eol = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Pixel = clamp(floor((log - black) * gain / 2^24), 0, 255)
  function automatic exp_t mapf(input int ci, input int cf, input longint black, input longint gain);
    exp_t   r;
    longint d, q;
    d = longint'(ci) * 65536 + longint'(cf) - black;
    q = (d * gain) >>> 24;
    r.sol  = 1'b0;
    r.eol  = 1'b0;
    r.clip = (q > 255);
    r.pix  = (q < 0) ? 0 : ((q > 255) ? 255 : int'(q));
    return r;
  endfunction

  // Compare process: sample between edges, check outputs, then advance the model
  always @(negedge clk) begin
    exp_t ex, got;
    bit   fire_out, fire_in;
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      expq.delete();
      m_black = 0; m_gain = 256; m_pblack = 0; m_pgain = 0;
      m_pend = 0; m_idx = 0; m_clip = 0; prev_stall = 0;
    end else begin
      check("in_ready", in_ready, (!out_valid || out_ready));
      check("clip_cnt", clip_cnt, m_clip);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_pix", pix, prev_pix);
        check("hold_sol", pix_sol, prev_sol);
        check("hold_eol", pix_eol, prev_eol);
      end
      fire_out = out_valid && out_ready;
      ex.clip = 1'b0;
      if (fire_out) begin
        got.pix = int'(pix); got.sol = pix_sol; got.eol = pix_eol; got.clip = 1'b0;
        obs.push_back(got);
        $display("out %0d: pix=%0d sol=%0d eol=%0d clip_cnt=%0d", n_out, pix, pix_sol, pix_eol, clip_cnt);
        n_out++;
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got pix %0d expected no output", pix);
        end else begin
          ex = expq.pop_front();
          check("pix", pix, ex.pix);
          check("sol", pix_sol, ex.sol);
          check("eol", pix_eol, ex.eol);
        end
      end
      fire_in = in_valid && (!out_valid || out_ready);
      if (fire_in) begin
        exp_t ni;
        if (m_idx == 0 && m_pend && !cfg_load) begin
          m_black = m_pblack; m_gain = m_pgain; m_pend = 0;
        end
        ni = mapf(int'(comp_int), int'(comp_frac), m_black, m_gain);
        ni.sol = (m_idx == 0);
        ni.eol = (m_idx == LL - 1);
        expq.push_back(ni);
        m_idx = (m_idx + 1) % LL;
      end
      if (cfg_load) begin
        m_pblack = longint'(cfg_black); m_pgain = longint'(cfg_gain); m_pend = 1;
        m_clip = 0;
      end else if (fire_out && ex.clip && m_clip < 65535) begin
        m_clip++;
      end
      prev_stall = out_valid && !out_ready;
      prev_pix = int'(pix); prev_sol = pix_sol; prev_eol = pix_eol;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_in(input int ci, input int cf);
    in_valid = 1'b1; comp_int = 6'(ci); comp_frac = 17'(cf);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input int b, input int g);
    cfg_black = 23'(b); cfg_gain = 16'(g); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; comp_int = '0; comp_frac = '0;
    cfg_black = '0; cfg_gain = '0; cfg_load = 1'b0; out_ready = 1'b1;

    // Pin the reference model with hand-computed values
    e = mapf(16, 0, 0, 256);            check("model_16", e.pix, 16);
    e = mapf(17, 'h9F22, 0, 256);       check("model_17", e.pix, 17);
    e = mapf(7, 0, 8 << 16, 512);       check("model_neg", e.pix, 0);
    e = mapf(16, 0, 8 << 16, 512);      check("model_gain", e.pix, 16);
    e = mapf(16, 0, 0, 4096);           check("model_clip", e.pix, 255);
    check("model_clipflag", e.clip, 1);

    idle(2);
    check("rst_pix", pix, 0);
    check("rst_clip", clip_cnt, 0);
    check("rst_sol", pix_sol, 0);
    reset = 1'b0;
    tick();

    // Default config, latency of three cycles
    in_valid = 1'b1; comp_int = 16; comp_frac = 0;
    tick();
    comp_int = 17; comp_frac = 17'h09F22;
    tick();
    check("lat_early", out_valid, 0);
    comp_int = 0; comp_frac = 0;
    tick();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_pix0", pix, 16);
    tick();
    check("lat_pix1", pix, 17);
    tick();
    check("lat_pix2", pix, 0);
    tick();
    check("lat_done", out_valid, 0);

    // New black/gain at the next line start; negative result clamps to zero
    drive_in(16, 0);
    cfg(8 << 16, 512);
    drive_in(16, 0);
    drive_in(7, 0);
    idle(5);
    check("cfg_pix16", obs[obs.size()-2].pix, 16);
    check("cfg_pix0", obs[obs.size()-1].pix, 0);

    // Clipping increments the counter; a config load clears it
    drive_in(16, 0);
    drive_in(16, 0);
    cfg(0, 4096);
    drive_in(16, 0);
    idle(5);
    check("clip_pix", obs[obs.size()-1].pix, 255);
    check("clip_one", clip_cnt, 1);
    cfg(0, 1024);
    check("clip_clear", clip_cnt, 0);

    // Reset with samples in flight
    drive_in(5, 0);
    drive_in(6, 0);
    reset = 1'b1;
    #1;
    check("flush_valid", out_valid, 0);
    tick();
    reset = 1'b0;
    tick();
    obs.delete();
    drive_in(16, 0);
    idle(5);
    check("post_rst_count", obs.size(), 1);
    if (obs.size() > 0) begin
      check("post_rst_pix", obs[0].pix, 16);
      check("post_rst_sol", obs[0].sol, 1);
    end

    // Line framing over 9 samples, config loaded mid-line
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    obs.delete();
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1; comp_int = 16; comp_frac = 0;
      if (k == 2) begin
        cfg_black = '0; cfg_gain = 16'd512; cfg_load = 1'b1;
      end
      tick();
      cfg_load = 1'b0;
    end
    in_valid = 1'b0;
    idle(6);
    check("frame_count", obs.size(), 9);
    for (int k = 0; k < obs.size(); k++) begin
      check($sformatf("frame_sol%0d", k), obs[k].sol, (k % LL) == 0);
      check($sformatf("frame_eol%0d", k), obs[k].eol, (k % LL) == LL - 1);
      check($sformatf("frame_pix%0d", k), obs[k].pix, (k < LL) ? 16 : 32);
    end

    // Randomized stream with backpressure and occasional config loads
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      comp_int  = 6'($urandom_range(0, 63));
      comp_frac = 17'($urandom_range(0, 17'h1FFFF));
      out_ready = ($urandom_range(0, 9) < 7);
      cfg_load  = ($urandom_range(0, 63) == 0);
      cfg_black = 23'($urandom_range(0, 48 << 16));
      cfg_gain  = 16'($urandom_range(0, 2047));
      tick();
    end
    cfg_load = 1'b0;

    // Five-cycle stall with input pending
    in_valid = 1'b1; out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      if (out_valid) check("stall_in_ready", in_ready, 0);
    end

    // Drain: every accepted sample must have come out exactly once
    in_valid = 1'b0; out_ready = 1'b1;
    idle(8);
    check("drain_empty", expq.size(), 0);
    check("drain_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
